avmm_vram_slave: RTL
====================

// Module: avmm_vram_slave
// PURPOSE
//   Avalon-MM slave responder that owns the pixel VRAM. Serves pipelined fixed-latency reads from the
//   VGA controller's VRAM master (avm_read/avm_address/avm_readdata/avm_readdatavalid/avm_waitrequest)
//   and accepts pixel writes from the core. Single clock domain (core side); on-chip RAM inferred inside.
// PARAMETERS
//   PWIDTH   8       pixel/data width
//   AWIDTH   19      address width
//   DEPTH    307200  implemented words (640x480); addresses >= DEPTH are out-of-range
//   LATENCY  4       read latency, accepted read -> readdatavalid, in cycles (>= 2)
//   MAXPEND  4       max outstanding reads (1..LATENCY); throttled via waitrequest
// PORTS
//   clk_core           in   1       core clock
//   rst_core           in   1       asynchronous, active-high reset
//   avs_address        in   AWIDTH  word address
//   avs_read           in   1       read request
//   avs_write          in   1       write request
//   avs_writedata      in   PWIDTH  write data
//   avs_waitrequest    out  1       stall; request not accepted while high
//   avs_readdata       out  PWIDTH  read data, valid when avs_readdatavalid=1
//   avs_readdatavalid  out  1       one-cycle pulse per accepted read, in order
//   err_oor            out  1       sticky: out-of-range access or read+write collision seen
//   err_clr            in   1       clears err_oor (synchronous)
// BEHAVIOUR
//   Clock/reset: one clock clk_core; rst_core asynchronous, active-high.
//   Reset values: avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0, err_oor=0, pend_cnt=0,
//     read pipeline valid bits=0. RAM contents are not reset.
//   Ready: internal rdy flop goes 1 on the first clock edge after rst_core deasserts;
//     avs_waitrequest = ~rdy | (pend_cnt == MAXPEND) | (rd_accept_pending_eq when MAXPEND hit).
//     Waitrequest is derived from registered state only (no comb path from avs_read/avs_write).
//   Accept: rd_acc = avs_read & ~avs_write & ~avs_waitrequest; wr_acc = avs_write & ~avs_waitrequest.
//   Collision: read and write both high with waitrequest low -> write accepted, read dropped
//     (no readdatavalid), err_oor set.
//   Write: wr_acc with address < DEPTH writes RAM at that edge; address >= DEPTH -> RAM untouched,
//     err_oor set.
//   Read: rd_acc at edge N -> avs_readdatavalid=1 and avs_readdata valid at edge N+LATENCY,
//     exactly one cycle. Back-to-back reads accepted every cycle -> data returned every cycle, in order.
//     Out-of-range read still returns (data=0) at N+LATENCY and sets err_oor.
//   Read-after-write: read accepted the cycle after a write to the same address returns the new data;
//     read and write to same address never accepted in the same cycle (collision rule).
//   avs_readdata holds its last value when avs_readdatavalid=0.
//   pend_cnt (width clog2(MAXPEND+1)): +1 on rd_acc, -1 on readdatavalid, unchanged when both;
//     never exceeds MAXPEND, never underflows. MAXPEND=LATENCY -> never throttles in steady state.
//   err_oor: set has priority over err_clr in the same cycle.
//   Reset mid-operation: all in-flight reads discarded; no readdatavalid for them after reset release.
// TESTING
//   T1 reset: hold rst_core 3 cycles, release -> waitrequest=1 then 0 on next edge; other outputs 0.
//   T2 write 0x5A @ 0x00010, read 0x00010 next cycle -> readdatavalid 4 cycles after accept, data 0x5A.
//   T3 stream reads addr 0..15 every cycle (preloaded data=addr) -> 16 consecutive valid pulses,
//      data 0..15 in order, waitrequest never high (MAXPEND=4).
//   T4 MAXPEND=2, LATENCY=4, read every cycle -> waitrequest high after 2 accepts, accept rate 2/4,
//      pend_cnt never > 2, all data returned in order.
//   T5 read @ 307200 -> readdata 0 after 4 cycles, err_oor=1; write @ 307201 -> RAM unchanged;
//      err_clr pulse -> err_oor=0 next edge.
//   T6 read+write same cycle -> write lands, no valid pulse, err_oor=1; assert rst_core while
//      3 reads in flight -> zero readdatavalid pulses after release.

Source files
------------

// File: rtl/avmm_vram_slave.sv
// Avalon-MM slave owning the pixel VRAM: fixed-latency pipelined reads, single-cycle writes,
// outstanding-read throttling via waitrequest and a sticky error flag.
module avmm_vram_slave #(
    parameter int unsigned PWIDTH  = 8,
    parameter int unsigned AWIDTH  = 19,
    parameter int unsigned DEPTH   = 307200,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned MAXPEND = 4
) (
    input  logic              clk_core,
    input  logic              rst_core,
    input  logic [AWIDTH-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [PWIDTH-1:0] avs_writedata,
    output logic              avs_waitrequest,
    output logic [PWIDTH-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    output logic              err_oor,
    input  logic              err_clr
);

    localparam int unsigned CW = $clog2(MAXPEND + 1);
    localparam logic [CW-1:0] MAXP = CW'(MAXPEND);
    localparam logic [AWIDTH:0] DEPTH_W = DEPTH[AWIDTH:0];

    logic                              r_rdy;
    logic [CW-1:0]                     r_pend;
    logic [CW-1:0]                     w_pend_d;
    logic [LATENCY-1:0]                r_vld;
    logic [LATENCY-1:0]                r_oor;
    logic [AWIDTH-1:0]                 r_raddr;
    logic [LATENCY-2:0][PWIDTH-1:0]    r_dat;
    logic [PWIDTH-1:0]                 r_mem [0:DEPTH-1];

    logic w_in_range;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_rd_done;
    logic w_err_set;

    assign w_in_range = ({1'b0, avs_address} < DEPTH_W);
    assign w_rd_done  = r_vld[LATENCY-1];
    // A read retiring this cycle frees a slot, so a full counter need not stall.
    assign avs_waitrequest = ~r_rdy | ((r_pend == MAXP) & ~w_rd_done);
    assign w_rd_acc   = avs_read & ~avs_write & ~avs_waitrequest;
    assign w_wr_acc   = avs_write & ~avs_waitrequest;
    assign w_err_set  = ((w_rd_acc | w_wr_acc) & ~w_in_range)
                      | (avs_read & avs_write & ~avs_waitrequest);

    always_comb begin
        w_pend_d = r_pend;
        if (w_rd_acc && !w_rd_done) begin
            w_pend_d = r_pend + 1'b1;
        end else if (!w_rd_acc && w_rd_done) begin
            w_pend_d = r_pend - 1'b1;
        end
    end

    // RAM and read-data pipeline: no reset so the array maps onto block RAM.
    always_ff @(posedge clk_core) begin
        if (w_wr_acc && w_in_range) begin
            r_mem[avs_address] <= avs_writedata;
        end
        r_dat[0] <= r_mem[r_raddr];
        for (int i = 1; i < int'(LATENCY) - 1; i++) begin
            r_dat[i] <= r_dat[i-1];
        end
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            r_rdy             <= 1'b0;
            r_pend            <= '0;
            r_vld             <= '0;
            r_oor             <= '0;
            r_raddr           <= '0;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
            err_oor           <= 1'b0;
        end else begin
            r_rdy             <= 1'b1;
            r_pend            <= w_pend_d;
            r_vld             <= {r_vld[LATENCY-2:0], w_rd_acc};
            r_oor             <= {r_oor[LATENCY-2:0], w_rd_acc & ~w_in_range};
            if (w_rd_acc) begin
                r_raddr <= w_in_range ? avs_address : '0;
            end
            avs_readdatavalid <= w_rd_done;
            if (w_rd_done) begin
                avs_readdata <= r_oor[LATENCY-1] ? '0 : r_dat[LATENCY-2];
            end
            if (w_err_set) begin
                err_oor <= 1'b1;
            end else if (err_clr) begin
                err_oor <= 1'b0;
            end
        end
    end

endmodule
